// File: rtl/serial_complementer.sv
// Multi-channel bit-serial LSB-first complementer.
// Every lane produces the pass-through, ones' complement or two's complement of its word.
// All lanes share one bit counter, one latched mode and one set of framing outputs.
// Each lane keeps its own seen_one flag and its own overflow flag.
module serial_complementer #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                x_valid,
    input  logic [CHANNELS-1:0] x,
    input  logic [1:0]          mode,
    output logic [CHANNELS-1:0] y,
    output logic                y_valid,
    output logic                y_last,
    output logic [CHANNELS-1:0] ovf
);

    localparam int             CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    localparam logic [1:0] MODE_ONES = 2'b01;
    localparam logic [1:0] MODE_TWOS = 2'b10;

    logic [CNT_W-1:0]    cnt;
    logic [1:0]          mode_q;
    logic [CHANNELS-1:0] seen_one;

    logic                first_bit;
    logic                last_bit;
    logic [1:0]          cur_mode;
    logic [CHANNELS-1:0] s;
    logic [CHANNELS-1:0] y_next;
    logic [CHANNELS-1:0] ovf_next;

    // Per-lane output bit for the current mode. Reserved mode 11 falls through to pass.
    function automatic logic [CHANNELS-1:0] complement(
        input logic [1:0]          m,
        input logic [CHANNELS-1:0] bits,
        input logic [CHANNELS-1:0] seen
    );
        case (m)
            MODE_ONES: complement = ~bits;
            MODE_TWOS: complement = bits ^ seen;
            default:   complement = bits;
        endcase
    endfunction

    // Word framing: bit 0 takes the live mode and starts seen_one fresh; later bits use the latched state.
    always_comb begin
        first_bit = (cnt == '0);
        last_bit  = (cnt == LAST);
        cur_mode  = first_bit ? mode : mode_q;
        s         = first_bit ? '0 : seen_one;
        y_next    = complement(cur_mode, x, s);
        ovf_next  = '0;
        if (cur_mode == MODE_TWOS && last_bit) begin
            // The MSB is set with no lower one, so the word is 100...0. Its negation does not fit in WIDTH bits.
            ovf_next = x & ~s;
        end
    end

    // Advance framing and load the registered outputs on each valid bit.
    // Idle cycles keep all state and clear the qualifiers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            mode_q   <= 2'b00;
            seen_one <= '0;
            y        <= '0;
            y_valid  <= 1'b0;
            y_last   <= 1'b0;
            ovf      <= '0;
        end else if (x_valid) begin
            cnt      <= last_bit ? '0 : cnt + CNT_W'(1);
            mode_q   <= cur_mode;
            seen_one <= s | x;
            y        <= y_next;
            y_valid  <= 1'b1;
            y_last   <= last_bit;
            ovf      <= ovf_next;
        end else begin
            y_valid  <= 1'b0;
            y_last   <= 1'b0;
            ovf      <= '0;
        end
    end

endmodule
